// File: rtl/jk_ff_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ff_bank_pkg
// Purpose : Shared definitions for the multi-mode flip-flop bank: the mode
//           encoding used on the per-cycle mode select.
// Ports   : (package, none)
// Rev     : 1.0  initial release
// ============================================================================
package ff_bank_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_JK = 2'b00;
  localparam mode_t MODE_D  = 2'b01;
  localparam mode_t MODE_T  = 2'b10;
  localparam mode_t MODE_SR = 2'b11;

endpackage
`default_nettype wire

// File: rtl/jk_ff_bank_if.sv
`default_nettype none
// ============================================================================
// Module  : jk_ff_bank_if
// Purpose : Control/status bundle of the flip-flop bank.
// Ports   : en, mode, a, b, err_clr (master -> bank)
//           q, q_n, changed, sr_err  (bank -> master)
//           cnt_clr / change_cnt only when FF_CHANGE_CNT_EN is defined
// Rev     : 1.0  initial release
// ============================================================================
interface jk_ff_bank_if
  import ff_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);

  logic             en;
  mode_t            mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             err_clr;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_n;
  logic             changed;
  logic             sr_err;
`ifdef FF_CHANGE_CNT_EN
  logic             cnt_clr;
  logic [CNT_W-1:0] change_cnt;

  modport master (
    output en, mode, a, b, err_clr, cnt_clr,
    input  q, q_n, changed, sr_err, change_cnt
  );
  modport slave (
    input  en, mode, a, b, err_clr, cnt_clr,
    output q, q_n, changed, sr_err, change_cnt
  );
`else
  modport master (
    output en, mode, a, b, err_clr,
    input  q, q_n, changed, sr_err
  );
  modport slave (
    input  en, mode, a, b, err_clr,
    output q, q_n, changed, sr_err
  );
`endif

  // Elaboration-time sanity check on the configuration.
  if (WIDTH < 1 || CNT_W < 1) begin : g_cfg_check
    $error("jk_ff_bank_if: WIDTH and CNT_W must be >= 1");
  end

endinterface
`default_nettype wire

// File: rtl/jk_ff_bank_cell.sv
`default_nettype none
// ============================================================================
// Module  : ff_cell
// Purpose : Next-state logic of one bank bit for the JK / D / T / SR modes.
//           Purely combinational; the state register lives in the top.
// Ports   : mode     in  2  operating mode shared by the whole bank
//           a        in  1  J / D / T / S operand
//           b        in  1  K / - / - / R operand
//           q        in  1  current state of this bit
//           q_next   out 1  state after the next enabled edge
//           conflict out 1  SR mode with S=R=1
// Rev     : 1.0  initial release
// ============================================================================
module ff_cell
  import ff_bank_pkg::*;
(
  input  mode_t mode,
  input  logic  a,
  input  logic  b,
  input  logic  q,
  output logic  q_next,
  output logic  conflict
);

  always_comb begin
    q_next   = q;
    conflict = 1'b0;
    case (mode)
      MODE_JK: begin
        case ({a, b})
          2'b01:   q_next = 1'b0;
          2'b10:   q_next = 1'b1;
          2'b11:   q_next = ~q;
          default: q_next = q;
        endcase
      end
      MODE_D:  q_next = a;
      MODE_T:  q_next = q ^ a;
      MODE_SR: begin
        case ({a, b})
          2'b10:   q_next = 1'b1;
          2'b01:   q_next = 1'b0;
          // Illegal S=R=1: keep the bit and report it upward.
          2'b11:   conflict = 1'b1;
          default: q_next = q;
        endcase
      end
      default: q_next = q;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/jk_ff_bank.sv
`default_nettype none
// ============================================================================
// Module  : jk_ff_bank
// Purpose : WIDTH-bit bank of multi-mode (JK/D/T/SR) flip-flops with clock
//           enable, a change pulse and a sticky SR-conflict error flag.
//           Optional macro FF_CHANGE_CNT_EN adds a saturating counter of
//           edges on which q changed, with its own clear.
// Ports   : clk    in  1  rising-edge clock
//           reset  in  1  synchronous active-high reset
//           bus    jk_ff_bank_if.slave  control/status bundle
// Rev     : 1.0  initial release
// ============================================================================
module jk_ff_bank
  import ff_bank_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT  = '0,
  parameter int               CNT_W = 16
)(
  input  logic               clk,
  input  logic               reset,
  jk_ff_bank_if.slave        bus
);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] conflict;
  logic             changed_r;
  logic             sr_err_r;
  logic             will_change;
  logic             conflict_hit;

  if (WIDTH < 1 || CNT_W < 1) begin : g_cfg_check
    $error("jk_ff_bank: WIDTH and CNT_W must be >= 1");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_cell u_cell (
      .mode     (bus.mode),
      .a        (bus.a[i]),
      .b        (bus.b[i]),
      .q        (q_r[i]),
      .q_next   (q_next[i]),
      .conflict (conflict[i])
    );
  end

  // Cells only raise conflict in SR mode, so an OR across the bank suffices.
  assign will_change  = bus.en && (q_next != q_r);
  assign conflict_hit = bus.en && (|conflict);

  always_ff @(posedge clk) begin
    if (reset) begin
      q_r       <= INIT;
      changed_r <= 1'b0;
      sr_err_r  <= 1'b0;
    end else begin
      if (bus.en) begin
        q_r <= q_next;
      end
      changed_r <= will_change;
      // A new conflict takes priority over a simultaneous clear.
      if (conflict_hit) begin
        sr_err_r <= 1'b1;
      end else if (bus.err_clr) begin
        sr_err_r <= 1'b0;
      end
    end
  end

  assign bus.q       = q_r;
  assign bus.q_n     = ~q_r;
  assign bus.changed = changed_r;
  assign bus.sr_err  = sr_err_r;

`ifdef FF_CHANGE_CNT_EN
  logic [CNT_W-1:0] cnt_r;

  // Counts the same edges that raise changed; clear beats increment and the
  // count sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset || bus.cnt_clr) begin
      cnt_r <= '0;
    end else if (will_change && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_r <= cnt_r + 1'b1;
    end
  end

  assign bus.change_cnt = cnt_r;
`endif

endmodule
`default_nettype wire

// File: tb/tb_jk_ff_bank.sv
`default_nettype none
// ============================================================================
// Module  : tb_jk_ff_bank
// Purpose : Directed self-checking bench for jk_ff_bank (WIDTH=8, INIT=A5,
//           CNT_W=2). Counter scenario only when FF_CHANGE_CNT_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
module tb_jk_ff_bank;
  import ff_bank_pkg::*;

  localparam int          WIDTH = 8;
  localparam int          CNT_W = 2;
  localparam logic [7:0]  INIT  = 8'hA5;

  logic clk;
  logic reset;
  int   passed;
  int   total;

  jk_ff_bank_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  jk_ff_bank #(.WIDTH(WIDTH), .INIT(INIT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    total++; if (bus.q !== 8'hA5) $display("FAIL reset_q: got %h want %h", bus.q, 8'hA5); else passed++;
    total++; if (bus.q_n !== 8'h5A) $display("FAIL reset_qn: got %h want %h", bus.q_n, 8'h5A); else passed++;
    total++; if (bus.changed !== 1'b0) $display("FAIL reset_changed: got %b want 0", bus.changed); else passed++;
    total++; if (bus.sr_err !== 1'b0) $display("FAIL reset_sr_err: got %b want 0", bus.sr_err); else passed++;
`ifdef FF_CHANGE_CNT_EN
    total++; if (bus.change_cnt !== 2'd0) $display("FAIL reset_cnt: got %0d want 0", bus.change_cnt); else passed++;
`endif
    reset = 1'b0;
  endtask

  task automatic test_jk();
    // A5: upper nibble toggles (A->5), lower nibble clears.
    bus.en = 1'b1; bus.mode = MODE_JK; bus.a = 8'hF0; bus.b = 8'hFF;
    step();
    total++; if (bus.q !== 8'h50) $display("FAIL jk_toggle_clear: got %h want %h", bus.q, 8'h50); else passed++;
    total++; if (bus.changed !== 1'b1) $display("FAIL jk_changed: got %b want 1", bus.changed); else passed++;
    bus.a = 8'h0F; bus.b = 8'h00;
    step();
    total++; if (bus.q !== 8'h5F) $display("FAIL jk_set: got %h want %h", bus.q, 8'h5F); else passed++;
    bus.a = 8'h00; bus.b = 8'h00;
    step();
    total++; if (bus.q !== 8'h5F) $display("FAIL jk_hold: got %h want %h", bus.q, 8'h5F); else passed++;
    total++; if (bus.changed !== 1'b0) $display("FAIL jk_hold_changed: got %b want 0", bus.changed); else passed++;
  endtask

  task automatic test_d_t();
    bus.mode = MODE_D; bus.a = 8'h5F; bus.b = 8'hFF;
    step();
    total++; if (bus.q !== 8'h5F) $display("FAIL d_same_q: got %h want %h", bus.q, 8'h5F); else passed++;
    total++; if (bus.changed !== 1'b0) $display("FAIL d_same_changed: got %b want 0", bus.changed); else passed++;
    bus.en = 1'b0; bus.mode = MODE_T; bus.a = 8'h01;
    step();
    total++; if (bus.q !== 8'h5F) $display("FAIL t_en0_q: got %h want %h", bus.q, 8'h5F); else passed++;
    total++; if (bus.changed !== 1'b0) $display("FAIL t_en0_changed: got %b want 0", bus.changed); else passed++;
    bus.en = 1'b1;
    step();
    total++; if (bus.q !== 8'h5E) $display("FAIL t_toggle: got %h want %h", bus.q, 8'h5E); else passed++;
    total++; if (bus.changed !== 1'b1) $display("FAIL t_changed: got %b want 1", bus.changed); else passed++;
    bus.mode = MODE_D; bus.a = 8'h3C; bus.b = 8'h00;
    step();
    total++; if (bus.q !== 8'h3C) $display("FAIL d_load: got %h want %h", bus.q, 8'h3C); else passed++;
    total++; if (bus.q_n !== 8'hC3) $display("FAIL d_load_qn: got %h want %h", bus.q_n, 8'hC3); else passed++;
  endtask

  task automatic test_sr();
    bus.mode = MODE_D; bus.a = 8'h00;
    step();
    // bit0 set, bit1 conflict (holds 0), bit2 clear.
    bus.mode = MODE_SR; bus.a = 8'h03; bus.b = 8'h06;
    step();
    total++; if (bus.q !== 8'h01) $display("FAIL sr_q: got %h want %h", bus.q, 8'h01); else passed++;
    total++; if (bus.sr_err !== 1'b1) $display("FAIL sr_err_set: got %b want 1", bus.sr_err); else passed++;
    total++; if (bus.changed !== 1'b1) $display("FAIL sr_changed: got %b want 1", bus.changed); else passed++;
    bus.a = 8'h01; bus.b = 8'h01; bus.err_clr = 1'b1;
    step();
    total++; if (bus.sr_err !== 1'b1) $display("FAIL sr_err_set_wins: got %b want 1", bus.sr_err); else passed++;
    total++; if (bus.q !== 8'h01) $display("FAIL sr_conflict_hold: got %h want %h", bus.q, 8'h01); else passed++;
    bus.a = 8'h00; bus.b = 8'h00;
    step();
    total++; if (bus.sr_err !== 1'b0) $display("FAIL sr_err_clr: got %b want 0", bus.sr_err); else passed++;
    bus.err_clr = 1'b0; bus.en = 1'b0; bus.a = 8'hFF; bus.b = 8'hFF;
    step();
    total++; if (bus.sr_err !== 1'b0) $display("FAIL sr_en0_no_err: got %b want 0", bus.sr_err); else passed++;
    total++; if (bus.q !== 8'h01) $display("FAIL sr_en0_hold: got %h want %h", bus.q, 8'h01); else passed++;
  endtask

`ifdef FF_CHANGE_CNT_EN
  task automatic test_counter();
    logic [1:0] exp_cnt [5];
    exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
    bus.en = 1'b0; bus.cnt_clr = 1'b1;
    step();
    total++; if (bus.change_cnt !== 2'd0) $display("FAIL cnt_clr_idle: got %0d want 0", bus.change_cnt); else passed++;
    bus.cnt_clr = 1'b0; bus.en = 1'b1; bus.mode = MODE_T; bus.a = 8'h01; bus.b = 8'h00;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (bus.change_cnt !== exp_cnt[i])
        $display("FAIL cnt_edge%0d: got %0d want %0d", i, bus.change_cnt, exp_cnt[i]);
      else passed++;
    end
    bus.cnt_clr = 1'b1;
    step();
    total++; if (bus.change_cnt !== 2'd0) $display("FAIL cnt_clr_wins: got %0d want 0", bus.change_cnt); else passed++;
    total++; if (bus.changed !== 1'b1) $display("FAIL cnt_clr_changed: got %b want 1", bus.changed); else passed++;
    bus.cnt_clr = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    bus.en = 1'b1; bus.mode = MODE_SR; bus.a = 8'h80; bus.b = 8'h80;
    step();
    total++; if (bus.sr_err !== 1'b1) $display("FAIL mid_pre_err: got %b want 1", bus.sr_err); else passed++;
    bus.mode = MODE_T; bus.a = 8'hFF; bus.b = 8'h00;
    step();
    reset = 1'b1;
    step();
    total++; if (bus.q !== 8'hA5) $display("FAIL mid_reset_q: got %h want %h", bus.q, 8'hA5); else passed++;
    total++; if (bus.changed !== 1'b0) $display("FAIL mid_reset_changed: got %b want 0", bus.changed); else passed++;
    total++; if (bus.sr_err !== 1'b0) $display("FAIL mid_reset_err: got %b want 0", bus.sr_err); else passed++;
`ifdef FF_CHANGE_CNT_EN
    total++; if (bus.change_cnt !== 2'd0) $display("FAIL mid_reset_cnt: got %0d want 0", bus.change_cnt); else passed++;
`endif
    reset = 1'b0; bus.en = 1'b0;
    step();
    total++; if (bus.q !== 8'hA5) $display("FAIL post_reset_hold: got %h want %h", bus.q, 8'hA5); else passed++;
    total++; if (bus.changed !== 1'b0) $display("FAIL post_reset_changed: got %b want 0", bus.changed); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset       = 1'b1;
    bus.en      = 1'b0;
    bus.mode    = MODE_JK;
    bus.a       = '0;
    bus.b       = '0;
    bus.err_clr = 1'b0;
`ifdef FF_CHANGE_CNT_EN
    bus.cnt_clr = 1'b0;
`endif
    test_reset();
    test_jk();
    test_d_t();
    test_sr();
`ifdef FF_CHANGE_CNT_EN
    test_counter();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
